// File: rtl/onehot_encoder_8to3_if.sv
// Request/index handshake bundle for onehot_encoder_8to3.
// slave  : encoder side (takes requests, produces indices)
// master : environment side (drives requests, consumes indices)
interface onehot_encoder_8to3_if #(
  parameter int IN_W   = 8,
  parameter int CODE_W = 3
);
  logic [IN_W-1:0]   in_vec;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_none;
  logic              out_multi;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_code, out_none, out_multi, out_valid
  );

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_code, out_none, out_multi, out_valid
  );
endinterface

// File: rtl/onehot_encoder_8to3.sv
// Registered 8-to-3 MSB-priority encoder behind a 2-entry skid queue.
// Optional saturating error counter enabled by macro ONEHOT_ENC_ERR_CNT_EN;
// without it err_count is tied to 0 and err_clr is ignored.
//
// state | meaning
// EMPTY | no entry queued, out_valid=0
// ONE   | head entry valid in slot 0
// TWO   | slots 0 (head) and 1 full, in_ready=0
module onehot_encoder_8to3 #(
  parameter int IN_W   = 8,
  parameter int CODE_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  onehot_encoder_8to3_if.slave bus,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   err_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam int E_W   = CODE_W + 2;
  localparam int POP_W = $clog2(IN_W + 1);

  logic [1:0]        state;
  logic [E_W-1:0]    ent0;
  logic [E_W-1:0]    ent1;
  logic [E_W-1:0]    enc_ent;
  logic [CODE_W-1:0] enc_code;
  logic [POP_W-1:0]  enc_pop;
  logic              enc_none;
  logic              enc_multi;
  logic              push;
  logic              pop;

  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Encode the incoming vector: highest set bit wins, count ones for multi-hot
  always_comb begin
    enc_code = '0;
    enc_pop  = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (bus.in_vec[i]) begin
        enc_code = CODE_W'(i);
        enc_pop  = enc_pop + POP_W'(1);
      end
    end
    enc_none  = (bus.in_vec == '0);
    enc_multi = (enc_pop > POP_W'(1));
  end

  assign enc_ent = {enc_code, enc_none, enc_multi};

  // Occupancy FSM; slot 0 is always the head so outputs come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            ent0  <= enc_ent;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              ent1  <= enc_ent;
              state <= TWO;
            end
            2'b11: ent0  <= enc_ent;
            2'b01: state <= EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            ent0  <= ent1;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.out_code  = ent0[E_W-1:2];
  assign bus.out_none  = ent0[1];
  assign bus.out_multi = ent0[0];

`ifdef ONEHOT_ENC_ERR_CNT_EN
  logic [CNT_W-1:0] err_q;

  // Count zero/multi-hot requests when accepted; clear has priority, saturate at max
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (err_clr) begin
      err_q <= '0;
    end else if (push && (enc_none || enc_multi) && (err_q != '1)) begin
      err_q <= err_q + CNT_W'(1);
    end
  end

  assign err_count = err_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_onehot_encoder_8to3.sv
// Self-checking bench for onehot_encoder_8to3: directed table, hand-written
// corner sequences and randomized traffic against a queue-based reference.
module tb_onehot_encoder_8to3;

  typedef struct packed {
    logic [2:0] code;
    logic       none;
    logic       multi;
  } exp_t;

  typedef struct {
    logic [7:0] vec;
    logic [2:0] code;
    logic       none;
    logic       multi;
  } vec_t;

`ifdef ONEHOT_ENC_ERR_CNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clr;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_err    = 0;
  int n_pops   = 0;
  int m_err    = 0;
  exp_t q[$];

  onehot_encoder_8to3_if bus ();

  onehot_encoder_8to3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the rules: floor(log2(v)) for the index, popcount for multi
  function automatic exp_t ref_enc(input logic [7:0] v);
    exp_t e;
    int   x;
    int   n;
    x = int'(v);
    n = 0;
    while (x > 1) begin
      x = x / 2;
      n++;
    end
    e.code  = 3'(n);
    e.none  = (v == 8'h00);
    e.multi = ($countones(v) > 1);
    return e;
  endfunction

  // Scoreboard: observe each cycle's transfers just before the rising edge
  always @(negedge clk) begin
    exp_t e;
    exp_t h;
    if (!rst_n) begin
      q.delete();
      m_err = 0;
    end else begin
      chk("in_ready", int'(bus.in_ready), int'(q.size() < 2));
      chk("out_valid", int'(bus.out_valid), int'(q.size() != 0));
      chk("err_count", int'(err_count), m_err);
      if (bus.out_valid && q.size() != 0) begin
        h = q[0];
        chk("out_code", int'(bus.out_code), int'(h.code));
        chk("out_none", int'(bus.out_none), int'(h.none));
        chk("out_multi", int'(bus.out_multi), int'(h.multi));
        if (bus.out_ready) begin
          void'(q.pop_front());
          n_pops++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = ref_enc(bus.in_vec);
        q.push_back(e);
      end
      if (ERR_EN != 0) begin
        if (err_clr) m_err = 0;
        else if (bus.in_valid && bus.in_ready && (bus.in_vec == 8'h00 || $countones(bus.in_vec) > 1)
                 && m_err < 255)
          m_err = m_err + 1;
      end
    end
  end

  vec_t tbl[12];

  initial begin
    int   acc;
    int   pops0;
    exp_t e;

    tbl[0]  = '{8'h01, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h80, 3'd7, 1'b0, 1'b0};
    tbl[2]  = '{8'b0010_0110, 3'd5, 1'b0, 1'b1};
    tbl[3]  = '{8'h00, 3'd0, 1'b1, 1'b0};
    tbl[4]  = '{8'hFF, 3'd7, 1'b0, 1'b1};
    tbl[5]  = '{8'h03, 3'd1, 1'b0, 1'b1};
    tbl[6]  = '{8'h08, 3'd3, 1'b0, 1'b0};
    tbl[7]  = '{8'h81, 3'd7, 1'b0, 1'b1};
    tbl[8]  = '{8'h40, 3'd6, 1'b0, 1'b0};
    tbl[9]  = '{8'h18, 3'd4, 1'b0, 1'b1};
    tbl[10] = '{8'h20, 3'd5, 1'b0, 1'b0};
    tbl[11] = '{8'h7E, 3'd6, 1'b0, 1'b1};

    bus.in_vec    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    err_clr       = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_code", int'(bus.out_code), 0);
    chk("rst_out_none", int'(bus.out_none), 0);
    chk("rst_out_multi", int'(bus.out_multi), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // One-hot sweep, back-to-back
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        bus.in_vec   = 8'(1 << i);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) chk("sweep_in_ready", int'(bus.in_ready), 1);
      if (i > 0) begin
        chk("sweep_valid", int'(bus.out_valid), 1);
        chk("sweep_code", int'(bus.out_code), i - 1);
        chk("sweep_flags", int'({bus.out_none, bus.out_multi}), 0);
      end
      @(posedge clk); #1;
    end

    // Table vectors, one at a time
    for (int i = 0; i < 12; i++) begin
      bus.in_vec   = tbl[i].vec;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_valid", int'(bus.out_valid), 1);
      chk("tbl_code", int'(bus.out_code), int'(tbl[i].code));
      chk("tbl_none", int'(bus.out_none), int'(tbl[i].none));
      chk("tbl_multi", int'(bus.out_multi), int'(tbl[i].multi));
      @(posedge clk); #1;
    end

    // Backpressure: fill both slots, third request must wait
    bus.out_ready = 1'b0;
    bus.in_vec    = 8'h04;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_vec = 8'h10;
    @(posedge clk); #1;
    bus.in_vec = 8'h40;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_head_code", int'(bus.out_code), 2);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 10 && acc == 0; k++) begin
      @(negedge clk);
      acc = int'(bus.in_ready);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("bp_accept_in_time", acc, 1);
    pops0 = n_pops;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", q.size(), 0);

    // Steady push+pop for 20 cycles: queue never fills
    pops0 = n_pops;
    for (int i = 0; i < 20; i++) begin
      bus.in_vec   = 8'(1 << $urandom_range(0, 7));
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("steady_in_ready", int'(bus.in_ready), 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("steady_outputs", n_pops - pops0, 20);

    // Reset with two entries queued
    bus.out_ready = 1'b0;
    bus.in_vec    = 8'h01;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_vec = 8'h02;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postrst_no_stale", int'(bus.out_valid), 0);
    end
    @(posedge clk); #1;

    // Error counter: saturation and clear-over-increment
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr      = 1'b0;
    bus.in_vec   = 8'h00;
    bus.in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("err_saturated", int'(err_count), (ERR_EN != 0) ? 255 : 0);
    @(posedge clk); #1;
    err_clr      = 1'b1;
    bus.in_vec   = 8'h00;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    err_clr      = 1'b0;
    bus.in_vec   = 8'h11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("err_clr_then_inc", int'(err_count), (ERR_EN != 0) ? 1 : 0);
    @(posedge clk); #1;

    // Randomized traffic; source holds data until accepted
    bus.in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = int'(bus.in_valid && bus.in_ready);
      @(posedge clk); #1;
      if (!bus.in_valid || acc != 0) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0:       bus.in_vec = 8'h00;
          1, 2:    bus.in_vec = 8'(1 << $urandom_range(0, 7));
          default: bus.in_vec = 8'($urandom);
        endcase
      end
      err_clr       = ($urandom_range(0, 31) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    bus.in_valid  = 1'b0;
    err_clr       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("final_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
